axi_lite_cmd_master: RTL and testbench

//  Hardware AXI4-Lite master; sits directly upstream of axi_lite_template and drives its slave port.

---
 rtl/axil_master_pkg.sv | 28 ++
 rtl/axi_lite_cmd_master.sv | 245 ++++++++++++++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_master_pkg.sv
// Shared types for the AXI4-Lite command master: response codes, FSM states
// and a small response-classification helper.
package axil_master_pkg;

    localparam int RESP_W = 2;

    typedef enum logic [RESP_W-1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axil_resp_e;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_B,
        RD_A,
        RD_D,
        RSP
    } state_e;

    // Anything other than OKAY counts as an error response.
    function automatic logic resp_is_err(input logic [RESP_W-1:0] resp);
        return axil_resp_e'(resp) != OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite master: turns a valid/ready command stream into single read/write
// transactions, one in flight. Optional error counter under AXIL_ERR_CNT_EN.
module axi_lite_cmd_master
    import axil_master_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter logic [2:0] AXPROT     = 3'b000
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [RESP_W-1:0]       rsp_resp,
    output logic                    busy,

    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [2:0]              awprot,
    output logic                    awvalid,
    input  logic                    awready,

    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,

    input  logic [RESP_W-1:0]       bresp,
    input  logic                    bvalid,
    output logic                    bready,

    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [2:0]              arprot,
    output logic                    arvalid,
    input  logic                    arready,

    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [RESP_W-1:0]       rresp,
    input  logic                    rvalid,
    output logic                    rready
`ifdef AXIL_ERR_CNT_EN
    ,
    output logic [15:0]             err_count
`endif
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;

    logic                    cmd_ready_d, busy_d;
    logic                    awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
    logic                    rsp_valid_d, rsp_write_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_d;
    logic [RESP_W-1:0]       rsp_resp_d;

    logic                    cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;

    // One address register serves both channels; only one valid is ever raised.
    assign awaddr = addr_q;
    assign araddr = addr_q;
    assign awprot = AXPROT;
    assign arprot = AXPROT;
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;

    assign cmd_hs = cmd_valid && cmd_ready;
    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign b_hs   = bvalid && bready;
    assign ar_hs  = arvalid && arready;
    assign r_hs   = rvalid && rready;
    assign rsp_hs = rsp_valid && rsp_ready;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        awvalid_d   = awvalid;
        wvalid_d    = wvalid;
        bready_d    = bready;
        arvalid_d   = arvalid;
        rready_d    = rready;
        rsp_valid_d = rsp_valid;
        rsp_write_d = rsp_write;
        rsp_rdata_d = rsp_rdata;
        rsp_resp_d  = rsp_resp;

        unique case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = RD_A;
                        arvalid_d = 1'b1;
                    end
                end
            end

            // AW and W complete independently, in either order.
            WR: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d  = WR_B;
                    bready_d = 1'b1;
                end
            end

            WR_B: begin
                if (b_hs) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = bresp;
                    state_d     = RSP;
                end
            end

            RD_A: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_D;
                end
            end

            RD_D: begin
                if (r_hs) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = rdata;
                    rsp_resp_d  = rresp;
                    state_d     = RSP;
                end
            end

            RSP: begin
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Decoded from the next state so both flags are plain flops.
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            cmd_ready <= cmd_ready_d;
            busy      <= busy_d;
            awvalid   <= awvalid_d;
            wvalid    <= wvalid_d;
            bready    <= bready_d;
            arvalid   <= arvalid_d;
            rready    <= rready_d;
            rsp_valid <= rsp_valid_d;
            rsp_write <= rsp_write_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_resp  <= rsp_resp_d;
        end
    end

`ifdef AXIL_ERR_CNT_EN
    logic resp_err;

    assign resp_err = (b_hs && (state_q == WR_B) && resp_is_err(bresp)) ||
                      (r_hs && (state_q == RD_D) && resp_is_err(rresp));

    // Saturating; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count <= '0;
        end else if (resp_err && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Self-checking bench for axi_lite_cmd_master with a behavioural AXI4-Lite
// slave (programmable AW/W ready delay and forced responses) and a scoreboard.
module tb_axi_lite_cmd_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr  = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy;

    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready;
    logic        bvalid_m, bready, arvalid, arready, rvalid_m, rready;
    logic        dut_bvalid, dut_rvalid;
    logic [1:0]  bresp, rresp;
    logic        stray_b = 1'b0;
    logic        stray_r = 1'b0;
`ifdef AXIL_ERR_CNT_EN
    logic [15:0] err_count;
`endif

    assign dut_bvalid = bvalid_m | stray_b;
    assign dut_rvalid = rvalid_m | stray_r;
    assign arready    = 1'b1;

    axi_lite_cmd_master dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .busy      (busy),
        .awaddr    (awaddr),
        .awprot    (awprot),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (dut_bvalid),
        .bready    (bready),
        .araddr    (araddr),
        .arprot    (arprot),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rvalid    (dut_rvalid),
        .rready    (rready)
`ifdef AXIL_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- slave model ----------------
    int          aw_delay = 0;
    int          w_delay  = 0;
    logic [1:0]  force_bresp = 2'b00;
    logic [1:0]  force_rresp = 2'b00;
    int          aw_wait, w_wait;
    logic        aw_got, w_got;
    logic [31:0] aw_addr_l, w_data_l;
    logic [3:0]  w_strb_l;
    logic [31:0] smem    [0:255];
    logic [31:0] ref_mem [0:255];

    initial begin
        for (int i = 0; i < 256; i++) begin
            smem[i]    = '0;
            ref_mem[i] = '0;
        end
    end

    always @(posedge clk or negedge rst) begin : slave_write
        logic [31:0] a, d, word;
        logic [3:0]  s;
        logic        aw_hs, w_hs;
        if (!rst) begin
            awready   <= (aw_delay == 0);
            wready    <= (w_delay == 0);
            aw_wait   <= 0;
            w_wait    <= 0;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            aw_addr_l <= '0;
            w_data_l  <= '0;
            w_strb_l  <= '0;
            bvalid_m  <= 1'b0;
            bresp     <= 2'b00;
        end else begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            if (!awvalid || aw_hs) begin
                awready <= (aw_delay == 0);
                aw_wait <= 0;
            end else begin
                if (aw_wait + 1 >= aw_delay - 1) awready <= 1'b1;
                aw_wait <= aw_wait + 1;
            end
            if (!wvalid || w_hs) begin
                wready <= (w_delay == 0);
                w_wait <= 0;
            end else begin
                if (w_wait + 1 >= w_delay - 1) wready <= 1'b1;
                w_wait <= w_wait + 1;
            end
            if (aw_hs) aw_addr_l <= awaddr;
            if (w_hs) begin
                w_data_l <= wdata;
                w_strb_l <= wstrb;
            end
            if (bvalid_m && bready) bvalid_m <= 1'b0;
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                a    = aw_hs ? awaddr : aw_addr_l;
                d    = w_hs ? wdata : w_data_l;
                s    = w_hs ? wstrb : w_strb_l;
                word = smem[a[9:2]];
                for (int b = 0; b < 4; b++) if (s[b]) word[8*b +: 8] = d[8*b +: 8];
                smem[a[9:2]] <= word;
                bvalid_m     <= 1'b1;
                bresp        <= force_bresp;
                aw_got       <= 1'b0;
                w_got        <= 1'b0;
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs)  w_got  <= 1'b1;
            end
        end
    end

    always @(posedge clk or negedge rst) begin : slave_read
        if (!rst) begin
            rvalid_m <= 1'b0;
            rdata    <= '0;
            rresp    <= 2'b00;
        end else begin
            if (rvalid_m && rready) rvalid_m <= 1'b0;
            if (arvalid && arready) begin
                rvalid_m <= 1'b1;
                rdata    <= smem[araddr[9:2]];
                rresp    <= force_rresp;
            end
        end
    end

    // ---------------- monitor ----------------
    int cyc   = 0;
    int aw_hi = 0;
    int w_hi  = 0;
    int b_cnt = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (awvalid) aw_hi = aw_hi + 1;
        if (wvalid)  w_hi  = w_hi + 1;
        if (dut_bvalid && bready) b_cnt = b_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got time=%0t required < 500000", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t exp_q[$];

    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output int c);
        int   n;
        exp_t e;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        c = cyc;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
            cmd_valid = 1'b0;
            return;
        end
        e.wr = wr;
        if (wr) begin
            for (int b = 0; b < 4; b++) if (s[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
            e.rdata = '0;
            e.resp  = force_bresp;
        end else begin
            e.rdata = ref_mem[a[9:2]];
            e.resp  = force_rresp;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // hold = cycles of rsp_ready backpressure; 0 means ready is raised early.
    task automatic get_rsp(input int hold, output int rc);
        int          n;
        exp_t        e;
        logic        s_wr;
        logic [31:0] s_rd;
        logic [1:0]  s_rs;
        rsp_ready = (hold == 0);
        n = 0;
        @(negedge clk);
        while (rsp_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        rc = cyc;
        total++;
        if (rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, n);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            rsp_ready = 1'b0;
            return;
        end
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rsp_unexpected: got wr=%b data=%h resp=%0d, required none", rsp_write, rsp_rdata, rsp_resp);
        end else begin
            e = exp_q.pop_front();
            if (rsp_write !== e.wr || rsp_rdata !== e.rdata || rsp_resp !== e.resp) begin
                bad++;
                $display("FAIL rsp_data: got wr=%b data=%h resp=%0d, required wr=%b data=%h resp=%0d",
                         rsp_write, rsp_rdata, rsp_resp, e.wr, e.rdata, e.resp);
            end
        end
        total++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rsp_state: got cmd_ready=%b busy=%b, required 0 1", cmd_ready, busy);
        end
        s_wr = rsp_write;
        s_rd = rsp_rdata;
        s_rs = rsp_resp;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b1 || rsp_write !== s_wr || rsp_rdata !== s_rd || rsp_resp !== s_rs ||
                cmd_ready !== 1'b0 || {awvalid, wvalid, arvalid} !== 3'b000) begin
                bad++;
                $display("FAIL rsp_hold[%0d]: got valid=%b wr=%b data=%h resp=%0d cmd_ready=%b axi_valids=%b, required 1 %b %h %0d 0 000",
                         k, rsp_valid, rsp_write, rsp_rdata, rsp_resp, cmd_ready,
                         {awvalid, wvalid, arvalid}, s_wr, s_rd, s_rs);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL rsp_release: got rsp_valid=%b cmd_ready=%b, required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy, cmd_ready} !== 8'b0000_0001) begin
            bad++;
            $display("FAIL reset_ctrl: got %b, required 00000001",
                     {awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy, cmd_ready});
        end
        total++;
        if ({rsp_write, rsp_rdata, rsp_resp} !== 35'd0) begin
            bad++;
            $display("FAIL reset_rsp: got wr=%b data=%h resp=%0d, required 0", rsp_write, rsp_rdata, rsp_resp);
        end
        total++;
        if ({awaddr, araddr, wdata, wstrb, awprot, arprot} !== 106'd0) begin
            bad++;
            $display("FAIL reset_axi: got awaddr=%h araddr=%h wdata=%h wstrb=%h prot=%b/%b, required 0",
                     awaddr, araddr, wdata, wstrb, awprot, arprot);
        end
`ifdef AXIL_ERR_CNT_EN
        total++;
        if (err_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_err_count: got %0d, required 0", err_count);
        end
`endif
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, cmd_ready, awvalid, arvalid} !== 4'b0100) begin
            bad++;
            $display("FAIL reset_release: got busy=%b cmd_ready=%b awvalid=%b arvalid=%b, required 0 1 0 0",
                     busy, cmd_ready, awvalid, arvalid);
        end
    endtask

    task automatic test_stray();
        stray_b = 1'b1;
        stray_r = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({bready, rready, busy, cmd_ready, rsp_valid} !== 5'b00010) begin
                bad++;
                $display("FAIL stray[%0d]: got bready=%b rready=%b busy=%b cmd_ready=%b rsp_valid=%b, required 0 0 0 1 0",
                         k, bready, rready, busy, cmd_ready, rsp_valid);
            end
        end
        stray_b = 1'b0;
        stray_r = 1'b0;
    endtask

    task automatic test_back_to_back();
        int c, rc;
        for (int i = 0; i < 32; i++) begin
            send_cmd(1'b1, 32'(4 * i), 32'(i), 4'hF, c);
            get_rsp(0, rc);
            send_cmd(1'b0, 32'(4 * i), 32'h0, 4'h0, c);
            get_rsp(0, rc);
        end
    endtask

    task automatic test_latency();
        int c, rc;
        send_cmd(1'b1, 32'h80, 32'h1234_5678, 4'hF, c);
        get_rsp(0, rc);
        total++;
        if (rc - c !== 3) begin
            bad++;
            $display("FAIL latency_write: got %0d cycles, required 3", rc - c);
        end
        send_cmd(1'b0, 32'h80, 32'h0, 4'h0, c);
        get_rsp(0, rc);
        total++;
        if (rc - c !== 3) begin
            bad++;
            $display("FAIL latency_read: got %0d cycles, required 3", rc - c);
        end
    endtask

    task automatic test_skew(input int awd, input int wd);
        int c, rc;
        aw_delay = awd;
        w_delay  = wd;
        @(negedge clk);
        aw_hi = 0;
        w_hi  = 0;
        b_cnt = 0;
        send_cmd(1'b1, 32'hC0 + 32'(awd), 32'hA5A5_0000 + 32'(wd), 4'hF, c);
        get_rsp(0, rc);
        total++;
        if (aw_hi !== (awd == 0 ? 1 : awd) || w_hi !== (wd == 0 ? 1 : wd) || b_cnt !== 1) begin
            bad++;
            $display("FAIL skew_aw%0d_w%0d: got aw_cycles=%0d w_cycles=%0d b_hs=%0d, required %0d %0d 1",
                     awd, wd, aw_hi, w_hi, b_cnt, (awd == 0 ? 1 : awd), (wd == 0 ? 1 : wd));
        end
        aw_delay = 0;
        w_delay  = 0;
        send_cmd(1'b0, 32'hC0 + 32'(awd), 32'h0, 4'h0, c);
        get_rsp(0, rc);
    endtask

    task automatic test_backpressure();
        int c, rc;
        send_cmd(1'b0, 32'h10, 32'h0, 4'h0, c);
        get_rsp(10, rc);
        send_cmd(1'b1, 32'h14, 32'hFEED_F00D, 4'hF, c);
        get_rsp(10, rc);
    endtask

    task automatic test_errors();
        int c, rc;
        force_rresp = 2'b11;
        send_cmd(1'b0, 32'h4, 32'h0, 4'h0, c);
        get_rsp(0, rc);
        force_rresp = 2'b00;
        force_bresp = 2'b10;
        send_cmd(1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, c);
        get_rsp(0, rc);
        force_bresp = 2'b00;
`ifdef AXIL_ERR_CNT_EN
        total++;
        if (err_count !== 16'd2) begin
            bad++;
            $display("FAIL err_count: got %0d, required 2", err_count);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int c, rc;
        aw_delay = 20;
        send_cmd(1'b1, 32'h3F0, 32'h0BAD_0BAD, 4'hF, c);
        repeat (3) @(negedge clk);
        total++;
        if (awvalid !== 1'b1 || awready !== 1'b0) begin
            bad++;
            $display("FAIL mid_pre: got awvalid=%b awready=%b, required 1 0", awvalid, awready);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({awvalid, wvalid, bready, busy, cmd_ready} !== 5'b00001) begin
            bad++;
            $display("FAIL mid_reset: got awvalid=%b wvalid=%b bready=%b busy=%b cmd_ready=%b, required 0 0 0 0 1",
                     awvalid, wvalid, bready, busy, cmd_ready);
        end
        exp_q.delete();
        aw_delay = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, cmd_ready, awvalid, rsp_valid} !== 4'b0100) begin
            bad++;
            $display("FAIL mid_release: got busy=%b cmd_ready=%b awvalid=%b rsp_valid=%b, required 0 1 0 0",
                     busy, cmd_ready, awvalid, rsp_valid);
        end
        send_cmd(1'b1, 32'h40, 32'hAABB_CCDD, 4'hF, c);
        get_rsp(0, rc);
        send_cmd(1'b1, 32'h40, 32'h1122_3344, 4'b0011, c);
        get_rsp(0, rc);
        send_cmd(1'b0, 32'h40, 32'h0, 4'h0, c);
        get_rsp(0, rc);
    endtask

    initial begin
        test_reset();
        test_stray();
        test_back_to_back();
        test_latency();
        test_skew(5, 0);
        test_skew(0, 5);
        test_backpressure();
        test_errors();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
